// File: rtl/gal.sv
// Bus-cycle glue logic: decodes each CPU cycle to RAM, ROM, CPLD or ATA.
// It drives the device selects and strobes for the whole cycle, then returns
// READYb after a wait that depends on the target.
module gal (
    input  logic clk,
    input  logic RESET,
    input  logic MIO,
    input  logic ADS,
    input  logic WR,
    input  logic A31,
    input  logic A13,
    input  logic A10,
    input  logic BE0b,
    input  logic BE1b,
    input  logic BE2b,
    input  logic BE3b,
    output logic READYb,
    output logic STATE0,
    output logic STATE1,
    output logic RAMCEb,
    output logic ROMCSb,
    output logic CPLDCSb,
    output logic ATACS0b,
    output logic ATAOEb,
    output logic WEb,
    output logic A1
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StS1   = 2'b01,
        StS2   = 2'b10,
        StS3   = 2'b11
    } state_e;

    typedef enum logic [2:0] {
        TgtNone = 3'd0,
        TgtRam  = 3'd1,
        TgtRom  = 3'd2,
        TgtCpld = 3'd3,
        TgtAta  = 3'd4
    } target_e;

    state_e  state_q;
    target_e target_q;
    target_e target_d;
    state_e  ready_st;
    logic    wr_q;
    logic    a1_q;
    logic    active;

    // Only the low half-word enables select the ROM half; the upper two are unused.
    logic unused_be;
    assign unused_be = BE2b ^ BE3b;

    // Address decode of the cycle being started.
    always_comb begin
        target_d = TgtNone;
        if (MIO) begin
            target_d = A31 ? TgtRom : TgtRam;
        end else if (!A13) begin
            target_d = TgtAta;
        end else if (A10) begin
            target_d = TgtCpld;
        end
    end

    // State in which the latched target completes its cycle.
    always_comb begin
        ready_st = StS2;
        unique case (target_q)
            TgtRam:  ready_st = StS1;
            TgtAta:  ready_st = StS3;
            default: ready_st = StS2;
        endcase
    end

    // Cycle sequencer; cycle info is latched only when a cycle starts in IDLE.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q  <= StIdle;
            target_q <= TgtNone;
            wr_q     <= 1'b0;
            a1_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!ADS) begin
                        state_q  <= StS1;
                        target_q <= target_d;
                        wr_q     <= WR;
                        a1_q     <= BE0b & BE1b;
                    end
                end
                StS1:    state_q <= (ready_st == StS1) ? StIdle : StS2;
                StS2:    state_q <= (ready_st == StS2) ? StIdle : StS3;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Selects and strobes follow the state and the latched cycle info.
    always_comb begin
        active  = (state_q != StIdle);
        READYb  = !(active && (state_q == ready_st));
        RAMCEb  = !(active && (target_q == TgtRam));
        ROMCSb  = !(active && (target_q == TgtRom) && !wr_q);
        CPLDCSb = !(active && (target_q == TgtCpld));
        ATACS0b = !(active && (target_q == TgtAta));
        ATAOEb  = !(active && (target_q == TgtAta) && !wr_q);
        WEb     = !(active && wr_q &&
                    ((target_q == TgtRam) || (target_q == TgtCpld) || (target_q == TgtAta)));
        STATE1  = state_q[1];
        STATE0  = state_q[0];
        A1      = a1_q;
    end

endmodule

// File: tb/tb_gal.sv
// Directed bench for gal; output vector is
// {STATE1,STATE0,READYb,RAMCEb,ROMCSb,CPLDCSb,ATACS0b,ATAOEb,WEb,A1}.
module tb_gal;

    logic clk = 1'b0;
    logic RESET, MIO, ADS, WR, A31, A13, A10, BE0b, BE1b, BE2b, BE3b;
    logic READYb, STATE0, STATE1, RAMCEb, ROMCSb, CPLDCSb, ATACS0b, ATAOEb, WEb, A1;
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [9:0] Idle0 = 10'b00_1_1111_1_1_0;
    localparam logic [9:0] Idle1 = 10'b00_1_1111_1_1_1;

    gal dut (
        .clk     (clk),
        .RESET   (RESET),
        .MIO     (MIO),
        .ADS     (ADS),
        .WR      (WR),
        .A31     (A31),
        .A13     (A13),
        .A10     (A10),
        .BE0b    (BE0b),
        .BE1b    (BE1b),
        .BE2b    (BE2b),
        .BE3b    (BE3b),
        .READYb  (READYb),
        .STATE0  (STATE0),
        .STATE1  (STATE1),
        .RAMCEb  (RAMCEb),
        .ROMCSb  (ROMCSb),
        .CPLDCSb (CPLDCSb),
        .ATACS0b (ATACS0b),
        .ATAOEb  (ATAOEb),
        .WEb     (WEb),
        .A1      (A1)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] outs();
        return {STATE1, STATE0, READYb, RAMCEb, ROMCSb, CPLDCSb, ATACS0b, ATAOEb, WEb, A1};
    endfunction

    task automatic check_val(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after an edge, well away from the next one.
    task automatic set_bus(input logic mio, input logic a31, input logic a13, input logic a10,
                           input logic wr, input logic [3:0] be);
        MIO = mio; A31 = a31; A13 = a13; A10 = a10; WR = wr;
        {BE3b, BE2b, BE1b, BE0b} = be;
    endtask

    task automatic step(input string tag, input logic [9:0] exp);
        @(posedge clk);
        #1;
        check_val(tag, outs(), exp);
    endtask

    initial begin
        RESET = 1'b0;
        ADS   = 1'b1;
        set_bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1111);
        #12;
        check_val("reset", outs(), Idle0);
        RESET = 1'b1;
        step("idle_no_ads", Idle0);

        // RAM read, BE=0000 -> A1=0
        set_bus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000); ADS = 1'b0;
        step("ram_rd_s1", 10'b01_0_0111_1_1_0); ADS = 1'b1;
        step("ram_rd_idle", Idle0);

        // RAM write
        set_bus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000); ADS = 1'b0;
        step("ram_wr_s1", 10'b01_0_0111_1_0_0); ADS = 1'b1;
        step("ram_wr_idle", Idle0);

        // ROM read BE=1100 -> A1=0
        set_bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100); ADS = 1'b0;
        step("rom_rd0_s1", 10'b01_1_1011_1_1_0); ADS = 1'b1;
        step("rom_rd0_s2", 10'b10_0_1011_1_1_0);
        step("rom_rd0_idle", Idle0);

        // ROM read BE=0011 -> A1=1, held through IDLE
        set_bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011); ADS = 1'b0;
        step("rom_rd1_s1", 10'b01_1_1011_1_1_1); ADS = 1'b1;
        step("rom_rd1_s2", 10'b10_0_1011_1_1_1);
        step("rom_rd1_idle", Idle1);
        step("a1_hold", Idle1);

        // ROM write: no select, no WEb, still completes in S2
        set_bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000); ADS = 1'b0;
        step("rom_wr_s1", 10'b01_1_1111_1_1_0); ADS = 1'b1;
        step("rom_wr_s2", 10'b10_0_1111_1_1_0);
        step("rom_wr_idle", Idle0);

        // CPLD write then read
        set_bus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000); ADS = 1'b0;
        step("cpld_wr_s1", 10'b01_1_1101_1_0_0); ADS = 1'b1;
        step("cpld_wr_s2", 10'b10_0_1101_1_0_0);
        step("cpld_wr_idle", Idle0);
        set_bus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000); ADS = 1'b0;
        step("cpld_rd_s1", 10'b01_1_1101_1_1_0); ADS = 1'b1;
        step("cpld_rd_s2", 10'b10_0_1101_1_1_0);
        step("cpld_rd_idle", Idle0);

        // ATA read (A10=1 is don't care)
        set_bus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000); ADS = 1'b0;
        step("ata_rd_s1", 10'b01_1_1110_0_1_0); ADS = 1'b1;
        step("ata_rd_s2", 10'b10_1_1110_0_1_0);
        step("ata_rd_s3", 10'b11_0_1110_0_1_0);
        step("ata_rd_idle", Idle0);

        // ATA write, A10=0
        set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000); ADS = 1'b0;
        step("ata_wr_s1", 10'b01_1_1110_1_0_0); ADS = 1'b1;
        step("ata_wr_s2", 10'b10_1_1110_1_0_0);
        step("ata_wr_s3", 10'b11_0_1110_1_0_0);
        step("ata_wr_idle", Idle0);

        // Unclaimed write: only READYb asserts
        set_bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000); ADS = 1'b0;
        step("none_s1", 10'b01_1_1111_1_1_0); ADS = 1'b1;
        step("none_s2", 10'b10_0_1111_1_1_0);
        step("none_idle", Idle0);

        // Back-to-back: ROM read, ATA write, ROM read with ADS held low
        set_bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000); ADS = 1'b0;
        step("b2b_rom_s1", 10'b01_1_1011_1_1_0);
        set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
        step("b2b_rom_s2", 10'b10_0_1011_1_1_0);
        step("b2b_rom_idle", Idle0);
        step("b2b_ata_s1", 10'b01_1_1110_1_0_0);
        set_bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011);
        step("b2b_ata_s2", 10'b10_1_1110_1_0_0);
        step("b2b_ata_s3", 10'b11_0_1110_1_0_0);
        step("b2b_ata_idle", Idle0);
        step("b2b_rom2_s1", 10'b01_1_1011_1_1_1);
        step("b2b_rom2_s2", 10'b10_0_1011_1_1_1);
        ADS = 1'b1;
        step("b2b_rom2_idle", Idle1);

        // Reset in S2 of an ATA read aborts at once
        set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111); ADS = 1'b0;
        step("rst_ata_s1", 10'b01_1_1110_0_1_1); ADS = 1'b1;
        step("rst_ata_s2", 10'b10_1_1110_0_1_1);
        #2;
        RESET = 1'b0;
        #1;
        check_val("rst_async", outs(), Idle0);
        ADS = 1'b0;
        step("rst_held", Idle0);
        RESET = 1'b1;
        ADS   = 1'b1;
        step("rst_release_idle", Idle0);
        set_bus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000); ADS = 1'b0;
        step("post_rst_ram_s1", 10'b01_0_0111_1_1_0); ADS = 1'b1;
        step("post_rst_idle", Idle0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
